// File: rtl/parking_disp_pkg.sv
// parking_disp_pkg: shared types and widths for the parking-distance display path
package parking_disp_pkg;
  typedef enum logic {ST_BLANK, ST_SHOW} scan_state_t;
  localparam int DIGIT_W = 4;
  localparam int DEF_NUM_DIGITS = 4;
endpackage

// File: rtl/seg_scan_ctrl_slot_timer.sv
// slot_timer: reloadable down-counter flagging the last cycle of a slot
module slot_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         done_o,
  output logic         done_d_o
);
  logic [W-1:0] cnt_d, cnt_q;
  logic         done_q;
  assign cnt_d    = load_i ? val_i : cnt_q - W'(1);
  assign done_d_o = cnt_d == '0;
  assign done_o   = done_q;
  always_ff @(posedge clk) begin
    cnt_q  <= cnt_d;
    done_q <= done_d_o;
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexes buffered digits onto a shared 7-seg decoder with guard slots, zero blanking and blink
module seg_scan_ctrl
  import parking_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int DWELL_CYCLES = 50000,
  parameter int GUARD_CYCLES = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
  input  logic                          load,
  input  logic                          alert,
  output logic [DIGIT_W-1:0]            bcd_out,
  output logic [NUM_DIGITS-1:0]         dig_en_n,
  output logic                          frame_done
);
  localparam int SW = DIGIT_W * NUM_DIGITS;
  localparam int CW = $clog2((DWELL_CYCLES > GUARD_CYCLES ? DWELL_CYCLES : GUARD_CYCLES) + 1);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  scan_state_t           state_d, state_q;
  logic [IW-1:0]         idx_d, idx_q;
  logic [SW-1:0]         shadow_d, shadow_q, pend_d, pend_q;
  logic                  pend_v_d, pend_v_q, blink_on_d, blink_on_q, blink_wrap;
  logic [BW-1:0]         blink_cnt_d, blink_cnt_q;
  logic [NUM_DIGITS-1:0] show_mask_d, den_d, den_q;
  logic [DIGIT_W-1:0]    bcd_d, bcd_q;
  logic                  fd_d, fd_q, t_done, t_done_d;
  logic [CW-1:0]         t_val;

  // reload value is for the slot being entered: GUARD after SHOW or reset, DWELL after BLANK
  assign t_val = (rst || state_q == ST_SHOW) ? CW'(GUARD_CYCLES - 1) : CW'(DWELL_CYCLES - 1);

  slot_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .load_i   (rst | t_done),
    .val_i    (t_val),
    .done_o   (t_done),
    .done_d_o (t_done_d)
  );

  always_comb begin
    state_d     = t_done ? (state_q == ST_SHOW ? ST_BLANK : ST_SHOW) : state_q;
    idx_d       = (t_done && state_q == ST_SHOW) ? (idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + IW'(1)) : idx_q;
    shadow_d    = fd_q ? (load ? digits_in : pend_v_q ? pend_q : shadow_q) : shadow_q;
    pend_d      = (load && !fd_q) ? digits_in : pend_q;
    pend_v_d    = fd_q ? 1'b0 : load | pend_v_q;
    blink_wrap  = blink_cnt_q == BW'(BLINK_FRAMES - 1);
    blink_on_d  = !alert ? 1'b1 : (fd_q && blink_wrap) ? !blink_on_q : blink_on_q;
    blink_cnt_d = !alert ? '0 : fd_q ? (blink_wrap ? '0 : blink_cnt_q + BW'(1)) : blink_cnt_q;
    for (int i = 0; i < NUM_DIGITS; i++) show_mask_d[i] = (i == 0) || ((shadow_d >> (DIGIT_W * i)) != '0);
    // outputs are computed from next-state values so they switch in step with the registers
    den_d = (state_d == ST_SHOW && show_mask_d[idx_d] && blink_on_d) ? ~(NUM_DIGITS'(1) << idx_d) : '1;
    bcd_d = shadow_d[DIGIT_W * idx_d +: DIGIT_W];
    fd_d  = state_d == ST_SHOW && t_done_d && idx_d == IW'(NUM_DIGITS - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BLANK;
      idx_q       <= '0;
      shadow_q    <= '0;
      pend_q      <= '0;
      pend_v_q    <= 1'b0;
      blink_on_q  <= 1'b1;
      blink_cnt_q <= '0;
      den_q       <= '1;
      bcd_q       <= '0;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      pend_q      <= pend_d;
      pend_v_q    <= pend_v_d;
      blink_on_q  <= blink_on_d;
      blink_cnt_q <= blink_cnt_d;
      den_q       <= den_d;
      bcd_q       <= bcd_d;
      fd_q        <= fd_d;
    end
  end

  assign bcd_out    = bcd_q;
  assign dig_en_n   = den_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed stimulus with a frame-position reference model feeding a scoreboard queue
module tb_seg_scan_ctrl;
  localparam int N = 4, D = 4, G = 2, BF = 2;
  localparam int SLOT = G + D, FRAME = N * SLOT;

  logic        clk = 1'b0, rst, load, alert;
  logic [15:0] din;
  logic [3:0]  bcd_out, dig_en_n;
  logic        frame_done;
  int          n_cmp = 0, n_bad = 0;
  logic [8:0]  exp_q[$];

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(N), .DWELL_CYCLES(D), .GUARD_CYCLES(G), .BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (din),
    .load       (load),
    .alert      (alert),
    .bcd_out    (bcd_out),
    .dig_en_n   (dig_en_n),
    .frame_done (frame_done)
  );

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got bcd=%h en=%b fd=%b, want bcd=%h en=%b fd=%b",
               nm, $time, act[8:5], act[4:1], act[0], exp[8:5], exp[4:1], exp[0]);
    end
  endtask

  function automatic logic [8:0] expect_out(input int pos, input logic [15:0] sh, input bit bon);
    int          slot = pos / SLOT;
    bit          show = (pos % SLOT) >= G;
    bit          vis = (slot == 0) || ((sh >> (4 * slot)) != 16'h0);
    logic [3:0]  one = 4'b0001;
    logic [3:0]  en = (show && vis && bon) ? ~(one << slot) : 4'hF;
    return {sh[4 * slot +: 4], en, pos == FRAME - 1};
  endfunction

  // reference: position within the frame plus the buffering/blink rules, one step per clock edge
  int          m_pos, m_bc;
  logic [15:0] m_sh, m_pd;
  bit          m_pv, m_bon, m_fd;
  always @(posedge clk) begin
    if (rst) begin
      m_pos = 0; m_sh = 0; m_pd = 0; m_pv = 0; m_bon = 1; m_bc = 0;
    end else begin
      m_fd = (m_pos == FRAME - 1);
      if (m_fd) begin
        m_sh = load ? din : (m_pv ? m_pd : m_sh);
        m_pv = 0;
      end else if (load) begin
        m_pd = din;
        m_pv = 1;
      end
      if (!alert) begin
        m_bon = 1; m_bc = 0;
      end else if (m_fd) begin
        if (m_bc == BF - 1) begin m_bon = !m_bon; m_bc = 0; end
        else m_bc++;
      end
      m_pos = (m_pos + 1) % FRAME;
    end
    exp_q.push_back(expect_out(m_pos, m_sh, m_bon));
  end

  always @(negedge clk) if (exp_q.size() > 0) chk("scan", {bcd_out, dig_en_n, frame_done}, exp_q.pop_front());

  initial begin
    rst = 1'b1; load = 1'b0; alert = 1'b0; din = 16'hABCD;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 520; c++) begin
      rst   = (c == 447);
      load  = c inside {10, 50, 119, 125, 130, 440};
      din   = c == 10  ? 16'h3210 : c == 50  ? 16'h0005 : c == 119 ? 16'h7777 :
              c == 125 ? 16'h1111 : c == 130 ? 16'h2222 : c == 440 ? 16'h4321 : 16'hABCD;
      alert = (c >= 170 && c < 340) || (c >= 350 && c < 390);
      if (c == 0)   chk("reset_state", {bcd_out, dig_en_n, frame_done}, {4'h0, 4'hF, 1'b0});
      if (c == 2)   chk("first_show", {bcd_out, dig_en_n, frame_done}, {4'h0, 4'hE, 1'b0});
      if (c == 23)  chk("first_frame_done", {bcd_out, dig_en_n, frame_done}, {4'h0, 4'hF, 1'b1});
      if (c == 29)  chk("frame1_digit0", {bcd_out, dig_en_n, frame_done}, {4'h0, 4'hE, 1'b0});
      if (c == 47)  chk("frame1_digit3", {bcd_out, dig_en_n, frame_done}, {4'h3, 4'h7, 1'b1});
      if (c == 146) chk("last_load_wins", {bcd_out, dig_en_n, frame_done}, {4'h2, 4'hE, 1'b0});
      if (c == 220) chk("blink_off", {bcd_out, dig_en_n, frame_done}, {4'h2, 4'hF, 1'b0});
      if (c == 448) chk("mid_slot_reset", {bcd_out, dig_en_n, frame_done}, {4'h0, 4'hF, 1'b0});
      @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
